// File: rtl/pacman_move_ctrl.sv
// Per-frame Pacman movement: latch buttons, probe the four neighbour tiles one at a time
// over a shared map read port, then commit. 10 cycles with an ungated port; each grant stall adds a cycle.
module pacman_move_ctrl #(
  parameter int TILE_SIZE = 8,
  parameter int MAP_COLS  = 32,
  parameter int MAP_ROWS  = 36,
  parameter int START_X   = 24,
  parameter int START_Y   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_stb,
  input  logic        BTNU,
  input  logic        BTND,
  input  logic        BTNR,
  input  logic        BTNL,
  output logic        map_req,
  output logic [10:0] map_addr,
  input  logic        map_gnt,
  input  logic [2:0]  map_rdata,
  output logic [8:0]  x_pac,
  output logic [8:0]  y_pac,
  output logic        busy,
  output logic        done,
  output logic        frame_miss
);

  localparam int TS = $clog2(TILE_SIZE);
  localparam int CS = $clog2(MAP_COLS);
  localparam logic [9:0] ROWS_W = 10'(MAP_ROWS);
  localparam logic [9:0] COLS_W = 10'(MAP_COLS);

  // Direction index k: 0=U, 1=D, 2=R, 3=L
  localparam logic [1:0] K_U = 2'd0;
  localparam logic [1:0] K_D = 2'd1;
  localparam logic [1:0] K_R = 2'd2;
  localparam logic [1:0] K_L = 2'd3;

  typedef enum logic [1:0] {IDLE, PROBE, WAIT, APPLY} state_t;

  state_t     state;
  logic [1:0] k;
  logic [3:0] btn;
  logic [3:0] blocked;

  logic [8:0]        col, row, col_l, row_u, x_m1, y_m1;
  logic [3:0]        probe_inb;
  logic [3:0][10:0]  probe_addr;
  logic [1:0]        k_nxt;
  logic              advance;
  logic              mv_u, mv_d, mv_r, mv_l;

  function automatic logic [10:0] tile_addr(input logic [8:0] c, input logic [8:0] r);
    tile_addr = 11'(c) + (11'(r) << CS);
  endfunction

  // Probe geometry comes from the pre-move position, which is frozen while busy.
  always_comb begin
    x_m1  = x_pac - 9'd1;
    y_m1  = y_pac - 9'd1;
    col   = x_pac >> TS;
    row   = y_pac >> TS;
    col_l = (x_pac == 9'd0) ? 9'd0 : (x_m1 >> TS);
    row_u = (y_pac == 9'd0) ? 9'd0 : (y_m1 >> TS);

    probe_inb[K_U] = (y_pac != 9'd0);
    probe_inb[K_D] = (({1'b0, row} + 10'd1) < ROWS_W);
    probe_inb[K_R] = (({1'b0, col} + 10'd1) < COLS_W);
    probe_inb[K_L] = (x_pac != 9'd0);

    probe_addr[K_U] = probe_inb[K_U] ? tile_addr(col, row_u)         : 11'd0;
    probe_addr[K_D] = probe_inb[K_D] ? tile_addr(col, row + 9'd1)    : 11'd0;
    probe_addr[K_R] = probe_inb[K_R] ? tile_addr(col + 9'd1, row)    : 11'd0;
    probe_addr[K_L] = probe_inb[K_L] ? tile_addr(col_l, row)         : 11'd0;
  end

  assign k_nxt   = k + 2'd1;
  assign advance = ((state == PROBE) && !map_req) || (state == WAIT);
  assign busy    = (state != IDLE);

  assign mv_u = btn[K_U] && !blocked[K_U];
  assign mv_d = btn[K_D] && !blocked[K_D];
  assign mv_r = btn[K_R] && !blocked[K_R];
  assign mv_l = btn[K_L] && !blocked[K_L];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      btn        <= 4'd0;
      blocked    <= 4'd0;
      map_req    <= 1'b0;
      map_addr   <= 11'd0;
      done       <= 1'b0;
      frame_miss <= 1'b0;
      x_pac      <= 9'(START_X);
      y_pac      <= 9'(START_Y);
    end else begin
      done       <= 1'b0;
      frame_miss <= frame_stb && (state != IDLE);

      case (state)
        IDLE: begin
          if (frame_stb) begin
            btn      <= {BTNL, BTNR, BTND, BTNU};
            k        <= 2'd0;
            state    <= PROBE;
            map_req  <= probe_inb[K_U];
            map_addr <= probe_addr[K_U];
          end
        end
        PROBE: begin
          if (map_req) begin
            if (map_gnt) begin
              map_req <= 1'b0;
              state   <= WAIT;
            end
          end else begin
            blocked[k] <= 1'b1;
          end
        end
        WAIT: begin
          blocked[k] <= (map_rdata != 3'd0);
        end
        APPLY: begin
          if (mv_d)      y_pac <= y_pac + 9'd1;
          else if (mv_u) y_pac <= y_pac - 9'd1;
          if (mv_l)      x_pac <= x_pac - 9'd1;
          else if (mv_r) x_pac <= x_pac + 9'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Shared step after an out-of-bounds probe or a returned tile.
      if (advance) begin
        if (k == K_L) begin
          state <= APPLY;
          done  <= 1'b1;
        end else begin
          k        <= k_nxt;
          state    <= PROBE;
          map_req  <= probe_inb[k_nxt];
          map_addr <= probe_addr[k_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl with a registered map memory model and request log.
module tb_pacman_move_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_stb;
  logic        BTNU, BTND, BTNR, BTNL;
  logic        map_req;
  logic [10:0] map_addr;
  logic        map_gnt;
  logic [2:0]  map_rdata;
  logic [8:0]  x_pac, y_pac;
  logic        busy, done, frame_miss;

  logic [2:0]  mem [0:2047];
  logic [2:0]  pend;
  logic [10:0] addr_log [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          viol    = 0;
  int          dc;
  int          cyc;

  always #5 clk = ~clk;

  pacman_move_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_stb  (frame_stb),
    .BTNU       (BTNU),
    .BTND       (BTND),
    .BTNR       (BTNR),
    .BTNL       (BTNL),
    .map_req    (map_req),
    .map_addr   (map_addr),
    .map_gnt    (map_gnt),
    .map_rdata  (map_rdata),
    .x_pac      (x_pac),
    .y_pac      (y_pac),
    .busy       (busy),
    .done       (done),
    .frame_miss (frame_miss)
  );

  // Map port responder: granted read returns data one cycle later.
  always @(negedge clk) begin
    if (map_req && map_gnt) begin
      addr_log.push_back(map_addr);
      pend = mem[map_addr];
    end
    if (map_req && !busy) viol++;
  end

  always @(posedge clk) map_rdata <= pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // b = {U,D,R,L}; buttons drop right after the strobe so only the latched copy matters.
  task automatic do_frame(input logic [3:0] b, output int done_cyc);
    int c;
    {BTNU, BTND, BTNR, BTNL} = b;
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    {BTNU, BTND, BTNR, BTNL} = 4'b0000;
    c = 1;
    while (done !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    done_cyc = (done === 1'b1) ? c : -1;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    frame_stb = 1'b0;
    {BTNU, BTND, BTNR, BTNL} = 4'b0000;
    map_gnt   = 1'b1;
    pend      = 3'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 3'd0;

    #12;
    check("rst_x", x_pac, 24);
    check("rst_y", y_pac, 8);
    check("rst_req", map_req, 0);
    check("rst_addr", map_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_miss", frame_miss, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty map, right move: probe order and latency
    addr_log.delete();
    do_frame(4'b0010, dc);
    check("r_done_cyc", dc, 9);
    check("r_x", x_pac, 25);
    check("r_y", y_pac, 8);
    check("r_nreq", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("r_addr0", addr_log[0], 3);
      check("r_addr1", addr_log[1], 67);
      check("r_addr2", addr_log[2], 36);
      check("r_addr3", addr_log[3], 34);
    end

    // Walls block right and up
    do_reset();
    mem[36] = 3'd1;
    do_frame(4'b0010, dc);
    check("wall_r_x", x_pac, 24);
    mem[36] = 3'd0;
    mem[3]  = 3'd1;
    do_frame(4'b1000, dc);
    check("wall_u_y", y_pac, 8);
    mem[3] = 3'd0;
    do_frame(4'b1000, dc);
    check("free_u_y", y_pac, 7);

    // Priority: down beats up, left beats right
    do_reset();
    do_frame(4'b1100, dc);
    check("ud_y", y_pac, 9);
    check("ud_x", x_pac, 24);
    do_reset();
    do_frame(4'b0011, dc);
    check("rl_x", x_pac, 23);

    // Walk to the top-left corner and probe outside the map
    do_reset();
    for (int i = 0; i < 8; i++) do_frame(4'b1001, dc);
    for (int i = 0; i < 16; i++) do_frame(4'b0001, dc);
    check("corner_x", x_pac, 0);
    check("corner_y", y_pac, 0);
    addr_log.delete();
    do_frame(4'b1001, dc);
    check("corner_done_cyc", dc, 7);
    check("corner_x_hold", x_pac, 0);
    check("corner_y_hold", y_pac, 0);
    check("corner_nreq", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check("corner_addr_d", addr_log[0], 32);
      check("corner_addr_r", addr_log[1], 1);
    end
    check("corner_blk_u", dut.blocked[0], 1);
    check("corner_blk_l", dut.blocked[3], 1);

    // Walk to the right edge column
    do_reset();
    for (int i = 0; i < 224; i++) do_frame(4'b0010, dc);
    check("edge_x", x_pac, 248);
    addr_log.delete();
    do_frame(4'b0010, dc);
    check("edge_done_cyc", dc, 8);
    check("edge_x_hold", x_pac, 248);
    check("edge_nreq", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("edge_addr_u", addr_log[0], 31);
      check("edge_addr_d", addr_log[1], 95);
      check("edge_addr_l", addr_log[2], 62);
    end
    check("edge_blk_r", dut.blocked[2], 1);

    // Grant stall on first probe plus a strobe while busy
    do_reset();
    map_gnt   = 1'b0;
    BTNR      = 1'b1;
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    BTNR      = 1'b0;
    cyc = 1;
    for (int i = 1; i <= 5; i++) begin
      check("stall_req", map_req, 1);
      check("stall_addr", map_addr, 3);
      if (i == 5) check("miss_pulse", frame_miss, 1);
      frame_stb = (i == 4);
      BTNL      = (i == 4);
      tick();
      cyc++;
    end
    frame_stb = 1'b0;
    BTNL      = 1'b0;
    map_gnt   = 1'b1;
    check("miss_one_cycle", frame_miss, 0);
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("stall_done_cyc", cyc, 14);
    tick();
    check("stall_x", x_pac, 25);
    check("stall_y", y_pac, 8);
    check("stall_idle", busy, 0);

    // Strobe coincident with done is a miss, not a restart
    do_reset();
    BTNR      = 1'b1;
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    BTNR      = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("coinc_done_cyc", cyc, 9);
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    check("coinc_miss", frame_miss, 1);
    check("coinc_busy", busy, 0);
    check("coinc_x", x_pac, 25);
    tick();
    check("coinc_busy2", busy, 0);
    check("coinc_x2", x_pac, 25);

    // Asynchronous reset mid-sequence
    do_reset();
    BTNR      = 1'b1;
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    BTNR      = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    check("abort_pre_req", map_req, 1);
    check("abort_pre_addr", map_addr, 36);
    #2;
    rst = 1'b1;
    #1;
    check("abort_req", map_req, 0);
    check("abort_busy", busy, 0);
    check("abort_x", x_pac, 24);
    check("abort_y", y_pac, 8);
    @(posedge clk);
    #1;
    rst = 1'b0;
    addr_log.delete();
    do_frame(4'b0010, dc);
    check("after_abort_done_cyc", dc, 9);
    check("after_abort_x", x_pac, 25);
    check("after_abort_nreq", addr_log.size(), 4);

    check("req_outside_probe", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
